// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 matrix keypad scanner with press/release debounce and valid/ready key events
module keypad_scan_ctrl #(
    parameter int         DWELL     = 1000,
    parameter int         DEB_N     = 4,
    parameter logic [3:0] IDLE_CODE = 4'd15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic       key_valid,
    input  logic       key_ready
);

    localparam int            DW         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int            CW         = $clog2(DEB_N + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_N - 1);

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DEB_P = 2'd1,
        HELD  = 2'd2,
        DEB_R = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] dwell_cnt;
    logic          sample;
    logic [1:0]    row;
    logic [1:0]    col_lat;
    logic [CW-1:0] deb_cnt;
    logic          any_key;
    logic [1:0]    col_enc;

    // Control strobes produced by the output decode, consumed by the datapath registers
    logic          adv_row;
    logic          lat_key;
    logic          deb_load;
    logic          deb_inc;
    logic          deb_clr;
    logic          press;
    logic          rel;

    // Dwell counter: one sample event on the last cycle of each row strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_cnt <= '0;
        end else if (sample) begin
            dwell_cnt <= '0;
        end else begin
            dwell_cnt <= dwell_cnt + DW'(1);
        end
    end

    assign sample = (dwell_cnt == DWELL_LAST);

    // Column priority encoder: lowest-numbered low column wins
    always_comb begin
        any_key = (col_n != 4'hF);
        col_enc = 2'd3;
        if (!col_n[0]) begin
            col_enc = 2'd0;
        end else if (!col_n[1]) begin
            col_enc = 2'd1;
        end else if (!col_n[2]) begin
            col_enc = 2'd2;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SCAN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state decode; transitions only happen on sample events
    always_comb begin
        state_nxt = state;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (any_key) state_nxt = DEB_P;
                end
                DEB_P: begin
                    if (!any_key || (col_enc != col_lat)) state_nxt = SCAN;
                    else if (deb_cnt == DEB_LAST)          state_nxt = HELD;
                end
                HELD: begin
                    if (!any_key) state_nxt = DEB_R;
                end
                DEB_R: begin
                    if (any_key)                   state_nxt = HELD;
                    else if (deb_cnt == DEB_LAST)  state_nxt = SCAN;
                end
                default: state_nxt = SCAN;
            endcase
        end
    end

    // FSM output decode into datapath strobes
    always_comb begin
        adv_row  = 1'b0;
        lat_key  = 1'b0;
        deb_load = 1'b0;
        deb_inc  = 1'b0;
        deb_clr  = 1'b0;
        press    = 1'b0;
        rel      = 1'b0;
        if (sample) begin
            case (state)
                SCAN: begin
                    if (any_key) begin
                        lat_key  = 1'b1;
                        deb_load = 1'b1;
                    end else begin
                        adv_row  = 1'b1;
                    end
                end
                DEB_P: begin
                    if (!any_key || (col_enc != col_lat)) begin
                        adv_row = 1'b1;
                        deb_clr = 1'b1;
                    end else if (deb_cnt == DEB_LAST) begin
                        press   = 1'b1;
                        deb_clr = 1'b1;
                    end else begin
                        deb_inc = 1'b1;
                    end
                end
                HELD: begin
                    if (!any_key) deb_load = 1'b1;
                end
                DEB_R: begin
                    if (any_key) begin
                        deb_clr = 1'b1;
                    end else if (deb_cnt == DEB_LAST) begin
                        rel     = 1'b1;
                        adv_row = 1'b1;
                        deb_clr = 1'b1;
                    end else begin
                        deb_inc = 1'b1;
                    end
                end
                default: begin
                    deb_clr = 1'b1;
                end
            endcase
        end
    end

    // Row pointer and registered active-low one-hot strobe; they rotate together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row   <= 2'd0;
            row_n <= 4'b1110;
        end else if (adv_row) begin
            row   <= row + 2'd1;
            row_n <= {row_n[2:0], row_n[3]};
        end
    end

    // Column captured when a candidate press is first seen
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_lat <= 2'd0;
        end else if (lat_key) begin
            col_lat <= col_enc;
        end
    end

    // Debounce counter shared by press and release qualification
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_cnt <= '0;
        end else if (deb_clr) begin
            deb_cnt <= '0;
        end else if (deb_load) begin
            deb_cnt <= CW'(1);
        end else if (deb_inc) begin
            deb_cnt <= deb_cnt + CW'(1);
        end
    end

    // Held-key code and level; follows the physical key even while an event is pending
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_code <= IDLE_CODE;
            key_down <= 1'b0;
        end else if (press) begin
            key_code <= {row, col_lat};
            key_down <= 1'b1;
        end else if (rel) begin
            key_code <= IDLE_CODE;
            key_down <= 1'b0;
        end
    end

    // Press event flag; acceptance wins, so a press arriving while one is pending is dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_valid <= 1'b0;
        end else if (key_valid && key_ready) begin
            key_valid <= 1'b0;
        end else if (press) begin
            key_valid <= 1'b1;
        end
    end

endmodule
